lift_scheduler: RTL and testbench

LIFT_SCHEDULER -- requirements
Module: lift_scheduler

---
 rtl/lift_pkg.sv | 16 +
 rtl/lift_target_sel.sv | 73 +++++++
 rtl/lift_scheduler.sv | 156 +++++++++++++++
 tb/tb_lift_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared definitions for the lift scheduler.
// Holds the default floor count, the default door dwell time, the derived
// floor-number width and the scheduler state encoding.
package lift_pkg;

   localparam int NUM_FLOORS_DEF  = 8;
   localparam int DOOR_CYCLES_DEF = 4;
   localparam int FLOOR_W_DEF     = $clog2(NUM_FLOORS_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } state_e;

endpackage

// File: rtl/lift_target_sel.sv
// Combinational nearest-call selector.
// Finds the closest pending floor strictly above and strictly below the car,
// then picks one according to the preferred sweep direction. If nothing lies
// in the preferred direction, it falls back to the other side and reports the
// reversed direction.
//   pending_i   : bitmap of outstanding calls
//   cur_floor_i : current car floor
//   dir_up_i    : preferred direction (1 = up, 0 = down)
//   found_o     : a candidate floor exists on either side
//   floor_o     : chosen floor
//   dir_up_o    : direction of travel to the chosen floor (1 = up)
module lift_target_sel import lift_pkg::*; #(
   parameter  int NUM_FLOORS = NUM_FLOORS_DEF,
   localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
   input  logic [NUM_FLOORS-1:0] pending_i,
   input  logic [FLOOR_W-1:0]    cur_floor_i,
   input  logic                  dir_up_i,
   output logic                  found_o,
   output logic [FLOOR_W-1:0]    floor_o,
   output logic                  dir_up_o
);

   logic               above_found;
   logic               below_found;
   logic [FLOOR_W-1:0] above_floor;
   logic [FLOOR_W-1:0] below_floor;

   always_comb begin
      above_found = 1'b0;
      below_found = 1'b0;
      above_floor = '0;
      below_floor = '0;
      // Scan downwards so the last hit above the car is the nearest one.
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending_i[i] && (i > int'(cur_floor_i))) begin
            above_found = 1'b1;
            above_floor = i[FLOOR_W-1:0];
         end
      end
      // Scan upwards so the last hit below the car is the nearest one.
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending_i[i] && (i < int'(cur_floor_i))) begin
            below_found = 1'b1;
            below_floor = i[FLOOR_W-1:0];
         end
      end
   end

   always_comb begin
      found_o  = above_found | below_found;
      floor_o  = '0;
      dir_up_o = dir_up_i;
      if (dir_up_i) begin
         if (above_found) begin
            floor_o  = above_floor;
            dir_up_o = 1'b1;
         end else begin
            floor_o  = below_floor;
            dir_up_o = 1'b0;
         end
      end else begin
         if (below_found) begin
            floor_o  = below_floor;
            dir_up_o = 1'b0;
         end else begin
            floor_o  = above_floor;
            dir_up_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lift_scheduler.sv
// Single-car lift scheduler (IDLE / MOVE / DOOR sweep controller).
// Collects floor calls into a pending bitmap, commands the car to the nearest
// call in the current sweep direction, retargets to calls passed on the way,
// and holds the door open for DOOR_CYCLES cycles at each stop.
//   clk, reset    : clock, synchronous active-high reset
//   call_valid    : a call for call_floor is presented this cycle
//   call_floor    : floor of the presented call
//   cur_floor     : current car floor
//   car_stopped   : car is stationary at cur_floor
//   target_floor  : commanded floor, target_valid marks it live
//   dir_up/down   : current sweep direction (both 0 until first move)
//   door_open     : door-open command
//   pending       : outstanding calls
//   busy          : not idle, or calls outstanding
module lift_scheduler import lift_pkg::*; #(
   parameter  int NUM_FLOORS  = NUM_FLOORS_DEF,
   parameter  int DOOR_CYCLES = DOOR_CYCLES_DEF,
   localparam int FLOOR_W     = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  call_valid,
   input  logic [FLOOR_W-1:0]    call_floor,
   input  logic [FLOOR_W-1:0]    cur_floor,
   input  logic                  car_stopped,
   output logic [FLOOR_W-1:0]    target_floor,
   output logic                  target_valid,
   output logic                  dir_up,
   output logic                  dir_down,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  busy
);

   localparam int               CNT_W    = $clog2(DOOR_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOOR_CYCLES - 1);

   state_e                  state_q, state_d;
   logic [NUM_FLOORS-1:0]   pending_q, pending_d;
   logic [FLOOR_W-1:0]      target_q, target_d;
   logic                    tvalid_q, tvalid_d;
   logic                    dir_up_q, dir_up_d;
   logic                    dir_down_q, dir_down_d;
   logic [CNT_W-1:0]        door_cnt_q, door_cnt_d;

   logic                    call_ok;
   logic [NUM_FLOORS-1:0]   set_mask;
   logic [NUM_FLOORS-1:0]   clr_mask;
   logic                    sel_found;
   logic [FLOOR_W-1:0]      sel_floor;
   logic                    sel_up;

   // No direction yet (both flags low) counts as a preference for up.
   lift_target_sel #(.NUM_FLOORS(NUM_FLOORS)) u_sel (
      .pending_i   (pending_q),
      .cur_floor_i (cur_floor),
      .dir_up_i    (dir_up_q | ~dir_down_q),
      .found_o     (sel_found),
      .floor_o     (sel_floor),
      .dir_up_o    (sel_up)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         target_q   <= '0;
         tvalid_q   <= 1'b0;
         dir_up_q   <= 1'b0;
         dir_down_q <= 1'b0;
         door_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         target_q   <= target_d;
         tvalid_q   <= tvalid_d;
         dir_up_q   <= dir_up_d;
         dir_down_q <= dir_down_d;
         door_cnt_q <= door_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      tvalid_d   = tvalid_q;
      dir_up_d   = dir_up_q;
      dir_down_d = dir_down_q;
      door_cnt_d = door_cnt_q;
      call_ok    = call_valid && (int'(call_floor) < NUM_FLOORS);
      set_mask   = '0;
      clr_mask   = '0;
      if (call_ok) begin
         set_mask[call_floor] = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (pending_q == '0) begin
               // nothing to do; direction is retained for the next sweep
            end else if (pending_q[cur_floor]) begin
               state_d              = DOOR;
               clr_mask[cur_floor]  = 1'b1;
               door_cnt_d           = '0;
            end else if (sel_found) begin
               state_d    = MOVE;
               target_d   = sel_floor;
               tvalid_d   = 1'b1;
               dir_up_d   = sel_up;
               dir_down_d = ~sel_up;
            end
         end
         MOVE: begin
            if ((cur_floor == target_q) && car_stopped) begin
               state_d            = DOOR;
               clr_mask[target_q] = 1'b1;
               tvalid_d           = 1'b0;
               door_cnt_d         = '0;
            end else if (call_ok &&
                         ((dir_up_q   && (call_floor > cur_floor) && (call_floor < target_q)) ||
                          (dir_down_q && (call_floor < cur_floor) && (call_floor > target_q)))) begin
               // A call the car will pass on the way becomes the new stop;
               // the old target stays pending via the bitmap.
               target_d = call_floor;
            end
         end
         DOOR: begin
            if (call_ok && (call_floor == cur_floor)) begin
               // Served by holding the door: no pending bit, counter restarts.
               set_mask   = '0;
               door_cnt_d = '0;
            end else if (door_cnt_q == CNT_LAST) begin
               state_d    = IDLE;
               door_cnt_d = '0;
            end else begin
               door_cnt_d = door_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Clear wins over set so a same-cycle call for the floor being served is absorbed.
      pending_d = (pending_q | set_mask) & ~clr_mask;
   end

   assign target_floor = target_q;
   assign target_valid = tvalid_q;
   assign dir_up       = dir_up_q;
   assign dir_down     = dir_down_q;
   assign door_open    = (state_q == DOOR);
   assign pending      = pending_q;
   assign busy         = (state_q != IDLE) || (|pending_q);

endmodule

// File: tb/tb_lift_scheduler.sv
// Testbench for lift_scheduler.
// Each scenario is a table of per-cycle steps (inputs + expected outputs).
// Expected output words are pushed to a scoreboard queue when the step is
// driven and popped/compared once the clock edge has produced the output.
// Main output word layout: {target_floor[2:0], target_valid, dir_up, dir_down,
// door_open, pending[7:0], busy}. A second 6-floor instance exercises calls
// that are representable on the 3-bit port but lie outside the served range.
module tb_lift_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       call_valid = 1'b0;
   logic [2:0] call_floor = '0;
   logic [2:0] cur_floor = '0;
   logic       car_stopped = 1'b0;
   logic [2:0] target_floor;
   logic       target_valid, dir_up, dir_down, door_open, busy;
   logic [7:0] pending;

   logic       s_call_valid = 1'b0;
   logic [2:0] s_call_floor = '0;
   logic [2:0] s_cur_floor = '0;
   logic [2:0] s_target_floor;
   logic       s_target_valid, s_dir_up, s_dir_down, s_door_open, s_busy;
   logic [5:0] s_pending;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] sb_q[$];

   typedef struct {
      logic        rst;
      logic        cv;
      logic [2:0]  cf;
      logic [2:0]  cur;
      logic        st;
      logic [15:0] exp;
   } step_t;

   always #5 clk = ~clk;

   lift_scheduler dut (
      .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
      .cur_floor(cur_floor), .car_stopped(car_stopped), .target_floor(target_floor),
      .target_valid(target_valid), .dir_up(dir_up), .dir_down(dir_down),
      .door_open(door_open), .pending(pending), .busy(busy)
   );

   lift_scheduler #(.NUM_FLOORS(6), .DOOR_CYCLES(4)) dut_small (
      .clk(clk), .reset(reset), .call_valid(s_call_valid), .call_floor(s_call_floor),
      .cur_floor(s_cur_floor), .car_stopped(1'b0), .target_floor(s_target_floor),
      .target_valid(s_target_valid), .dir_up(s_dir_up), .dir_down(s_dir_down),
      .door_open(s_door_open), .pending(s_pending), .busy(s_busy)
   );

   wire [15:0] obs   = {target_floor, target_valid, dir_up, dir_down, door_open, pending, busy};
   wire [15:0] obs_s = {2'b00, s_target_floor, s_target_valid, s_door_open, s_pending, s_busy, s_dir_up, s_dir_down};

   function automatic logic [15:0] ev(input logic [2:0] tf, input logic tv, up, dn, door,
                                      input logic [7:0] pend, input logic bz);
      return {tf, tv, up, dn, door, pend, bz};
   endfunction

   function automatic step_t mk(input logic rst, cv, input logic [2:0] cf, cur,
                                input logic st, input logic [15:0] e);
      step_t s;
      s.rst = rst; s.cv = cv; s.cf = cf; s.cur = cur; s.st = st; s.exp = e;
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [15:0] Z = 16'h0000;

   task automatic test_reset();
      step_t       tbl[$];
      logic [15:0] e;
      tbl.push_back(mk(1, 1, 5, 0, 0, Z));   // reset dominates a live call
      tbl.push_back(mk(0, 0, 0, 0, 0, Z));
      tbl.push_back(mk(0, 0, 0, 0, 0, Z));
      foreach (tbl[k]) begin
         reset = tbl[k].rst; call_valid = tbl[k].cv; call_floor = tbl[k].cf;
         cur_floor = tbl[k].cur; car_stopped = tbl[k].st;
         sb_q.push_back(tbl[k].exp);
         tick();
         e = sb_q.pop_front(); n_tests++;
         if (obs !== e) begin n_fail++; $display("FAIL reset[%0d]: got %h expected %h", k, obs, e); end
         else $display("[TB] reset[%0d] ok %h", k, obs);
      end
      call_valid = 1'b0;
   endtask

   task automatic test_out_of_range();
      logic [2:0]  fl[4]  = '{3'd6, 3'd7, 3'd6, 3'd5};
      logic [15:0] ex[4];
      logic [15:0] e;
      ex[0] = Z; ex[1] = Z; ex[2] = Z;
      ex[3] = {2'b00, 3'd0, 1'b0, 1'b0, 6'h20, 1'b1, 1'b0, 1'b0};
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         s_call_valid = 1'b1; s_call_floor = fl[k];
         sb_q.push_back(ex[k]);
         tick();
         e = sb_q.pop_front(); n_tests++;
         if (obs_s !== e) begin n_fail++; $display("FAIL range[%0d] floor %0d: got %h expected %h", k, fl[k], obs_s, e); end
         else $display("[TB] range[%0d] floor %0d ok %h", k, fl[k], obs_s);
      end
      s_call_valid = 1'b0;
   endtask

   task automatic test_basic();
      step_t       tbl[$];
      logic [15:0] e;
      tbl.push_back(mk(1, 0, 0, 0, 0, Z));
      tbl.push_back(mk(0, 1, 5, 0, 0, ev(0, 0, 0, 0, 0, 8'h20, 1)));
      tbl.push_back(mk(0, 0, 0, 0, 0, ev(5, 1, 1, 0, 0, 8'h20, 1)));
      tbl.push_back(mk(0, 0, 0, 0, 0, ev(5, 1, 1, 0, 0, 8'h20, 1)));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 5, 1, ev(5, 0, 1, 0, 1, 8'h00, 1)));
      tbl.push_back(mk(0, 0, 0, 5, 1, ev(5, 0, 1, 0, 0, 8'h00, 0)));
      tbl.push_back(mk(0, 0, 0, 5, 1, ev(5, 0, 1, 0, 0, 8'h00, 0)));
      foreach (tbl[k]) begin
         reset = tbl[k].rst; call_valid = tbl[k].cv; call_floor = tbl[k].cf;
         cur_floor = tbl[k].cur; car_stopped = tbl[k].st;
         sb_q.push_back(tbl[k].exp);
         tick();
         e = sb_q.pop_front(); n_tests++;
         if (obs !== e) begin n_fail++; $display("FAIL basic[%0d]: got %h expected %h", k, obs, e); end
         else $display("[TB] basic[%0d] ok %h", k, obs);
      end
      call_valid = 1'b0;
   endtask

   task automatic test_sweep();
      step_t       tbl[$];
      logic [15:0] e;
      tbl.push_back(mk(1, 0, 0, 3, 1, Z));
      tbl.push_back(mk(0, 1, 3, 3, 1, ev(0, 0, 0, 0, 0, 8'h08, 1)));
      tbl.push_back(mk(0, 0, 0, 3, 1, ev(0, 0, 0, 0, 1, 8'h00, 1)));
      tbl.push_back(mk(0, 1, 1, 3, 1, ev(0, 0, 0, 0, 1, 8'h02, 1)));
      tbl.push_back(mk(0, 1, 6, 3, 1, ev(0, 0, 0, 0, 1, 8'h42, 1)));
      tbl.push_back(mk(0, 0, 0, 3, 1, ev(0, 0, 0, 0, 1, 8'h42, 1)));
      tbl.push_back(mk(0, 0, 0, 3, 1, ev(0, 0, 0, 0, 0, 8'h42, 1)));
      tbl.push_back(mk(0, 0, 0, 3, 0, ev(6, 1, 1, 0, 0, 8'h42, 1)));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 6, 1, ev(6, 0, 1, 0, 1, 8'h02, 1)));
      tbl.push_back(mk(0, 0, 0, 6, 1, ev(6, 0, 1, 0, 0, 8'h02, 1)));
      tbl.push_back(mk(0, 0, 0, 6, 0, ev(1, 1, 0, 1, 0, 8'h02, 1)));
      foreach (tbl[k]) begin
         reset = tbl[k].rst; call_valid = tbl[k].cv; call_floor = tbl[k].cf;
         cur_floor = tbl[k].cur; car_stopped = tbl[k].st;
         sb_q.push_back(tbl[k].exp);
         tick();
         e = sb_q.pop_front(); n_tests++;
         if (obs !== e) begin n_fail++; $display("FAIL sweep[%0d]: got %h expected %h", k, obs, e); end
         else $display("[TB] sweep[%0d] ok %h", k, obs);
      end
      call_valid = 1'b0;
   endtask

   task automatic test_retarget();
      step_t       tbl[$];
      logic [15:0] e;
      tbl.push_back(mk(1, 0, 0, 0, 0, Z));
      tbl.push_back(mk(0, 1, 6, 0, 0, ev(0, 0, 0, 0, 0, 8'h40, 1)));
      tbl.push_back(mk(0, 0, 0, 0, 0, ev(6, 1, 1, 0, 0, 8'h40, 1)));
      tbl.push_back(mk(0, 1, 4, 2, 0, ev(4, 1, 1, 0, 0, 8'h50, 1)));  // between: retarget
      tbl.push_back(mk(0, 1, 4, 2, 0, ev(4, 1, 1, 0, 0, 8'h50, 1)));  // current target: no change
      tbl.push_back(mk(0, 1, 1, 2, 0, ev(4, 1, 1, 0, 0, 8'h52, 1)));  // behind the car
      tbl.push_back(mk(0, 1, 5, 2, 0, ev(4, 1, 1, 0, 0, 8'h72, 1)));  // beyond target
      tbl.push_back(mk(0, 1, 2, 2, 0, ev(4, 1, 1, 0, 0, 8'h76, 1)));  // at car floor: not strictly between
      tbl.push_back(mk(0, 1, 3, 2, 0, ev(3, 1, 1, 0, 0, 8'h7E, 1)));  // between again
      tbl.push_back(mk(1, 1, 7, 3, 1, Z));                            // reset mid-MOVE
      tbl.push_back(mk(0, 0, 0, 3, 1, Z));
      foreach (tbl[k]) begin
         reset = tbl[k].rst; call_valid = tbl[k].cv; call_floor = tbl[k].cf;
         cur_floor = tbl[k].cur; car_stopped = tbl[k].st;
         sb_q.push_back(tbl[k].exp);
         tick();
         e = sb_q.pop_front(); n_tests++;
         if (obs !== e) begin n_fail++; $display("FAIL retarget[%0d]: got %h expected %h", k, obs, e); end
         else $display("[TB] retarget[%0d] ok %h", k, obs);
      end
      call_valid = 1'b0;
   endtask

   task automatic test_door_restart();
      step_t       tbl[$];
      logic [15:0] e;
      tbl.push_back(mk(1, 0, 0, 2, 1, Z));
      tbl.push_back(mk(0, 1, 2, 2, 1, ev(0, 0, 0, 0, 0, 8'h04, 1)));
      tbl.push_back(mk(0, 1, 2, 2, 1, ev(0, 0, 0, 0, 1, 8'h00, 1)));  // same-cycle call absorbed, door 1
      tbl.push_back(mk(0, 0, 0, 2, 1, ev(0, 0, 0, 0, 1, 8'h00, 1)));  // door 2
      tbl.push_back(mk(0, 0, 0, 2, 1, ev(0, 0, 0, 0, 1, 8'h00, 1)));  // door 3
      tbl.push_back(mk(0, 1, 2, 2, 1, ev(0, 0, 0, 0, 1, 8'h00, 1)));  // call during door 3: restart
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 2, 1, ev(0, 0, 0, 0, 1, 8'h00, 1)));
      tbl.push_back(mk(0, 0, 0, 2, 1, Z));
      foreach (tbl[k]) begin
         reset = tbl[k].rst; call_valid = tbl[k].cv; call_floor = tbl[k].cf;
         cur_floor = tbl[k].cur; car_stopped = tbl[k].st;
         sb_q.push_back(tbl[k].exp);
         tick();
         e = sb_q.pop_front(); n_tests++;
         if (obs !== e) begin n_fail++; $display("FAIL door[%0d]: got %h expected %h", k, obs, e); end
         else $display("[TB] door[%0d] ok %h", k, obs);
      end
      call_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_out_of_range();
      test_basic();
      test_sweep();
      test_retarget();
      test_door_restart();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
